// File: rtl/out_uart_tx_pkg.sv
// -----------------------------------------------------------------------------
// cpu_io_pkg
// Shared definitions for the processor serial output stage: transmitter FSM
// state encoding and frame geometry constants.
// -----------------------------------------------------------------------------
package cpu_io_pkg;

   // Transmitter FSM states, 2-bit encoding.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } state_e;

   // One 8N1 frame: start + 8 data + stop.
   localparam int FRAME_BITS = 10;
   // Bytes sent per 16-bit processor word.
   localparam int WORD_BYTES = 2;

endpackage

// File: rtl/out_uart_tx_baud_tick.sv
// -----------------------------------------------------------------------------
// baud_tick
// Bit-period timer for the UART transmitter. Counts 0..CLKS_PER_BIT-1 and
// flags the terminal count; restart holds the count at zero so every bit
// period measured after a restart is a full CLKS_PER_BIT cycles.
//
// Ports:
//   clock   in   system clock
//   reset   in   synchronous active-high reset
//   restart in   force the counter back to zero
//   tick    out  high during the last cycle of each bit period
// -----------------------------------------------------------------------------
module baud_tick #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic clock,
   input  logic reset,
   input  logic restart,
   output logic tick
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      if (restart || cnt_q == LAST) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values, independent of the order the always blocks run in.
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = (cnt_q == LAST);

endmodule

// File: rtl/out_uart_tx.sv
// -----------------------------------------------------------------------------
// out_uart_tx
// Serial output stage for the processor's 16-bit out port. Any change of
// out_word is captured in a one-entry pending buffer and later sent as two
// 8N1 bytes, high byte first, LSB first within each byte.
//
// Ports:
//   clock    in   system clock
//   reset    in   synchronous active-high reset
//   out_word in   processor out port, sampled every cycle
//   tx       out  UART line, idle high
//   busy     out  high while a frame pair is on the line
//   pending  out  high while a word waits in the buffer
//   overrun  out  one-cycle pulse when an unsent buffered word is replaced
// -----------------------------------------------------------------------------
module out_uart_tx
   import cpu_io_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] out_word,
   output logic        tx,
   output logic        busy,
   output logic        pending,
   output logic        overrun
);

   state_e      state_q, state_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic        byte_sel_q, byte_sel_d;   // 0 = high byte, 1 = low byte
   logic [15:0] word_q, word_d;           // word currently on the line
   logic        tx_q, tx_d;
   logic        busy_q, busy_d;
   logic        pending_q, pending_d;
   logic [15:0] pend_word_q, pend_word_d;
   logic [15:0] prev_q;
   logic        overrun_q, overrun_d;

   logic        tick;
   logic        load;
   logic        change;
   logic [7:0]  cur_byte;
   logic [2:0]  nxt_idx;

   // Counter sits at zero while idle, so the start bit gets a full period.
   baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clock   (clock),
      .reset   (reset),
      .restart (state_q == ST_IDLE),
      .tick    (tick)
   );

   assign cur_byte = byte_sel_q ? word_q[7:0] : word_q[15:8];
   assign nxt_idx  = bit_idx_q + 3'd1;
   assign change   = (out_word != prev_q);

   // NOTE: every signal driven here gets a default first, so no path through
   // the case leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d    = state_q;
      bit_idx_d  = bit_idx_q;
      byte_sel_d = byte_sel_q;
      word_d     = word_q;
      tx_d       = tx_q;
      busy_d     = busy_q;
      load       = 1'b0;

      // tx_d is the line level for the state being entered, so tx is a flop.
      case (state_q)
         ST_IDLE: begin
            tx_d = 1'b1;
            if (pending_q) begin
               load       = 1'b1;
               word_d     = pend_word_q;
               byte_sel_d = 1'b0;
               bit_idx_d  = 3'd0;
               state_d    = ST_START;
               tx_d       = 1'b0;
               busy_d     = 1'b1;
            end
         end
         ST_START: begin
            if (tick) begin
               state_d   = ST_DATA;
               bit_idx_d = 3'd0;
               tx_d      = cur_byte[0];
            end
         end
         ST_DATA: begin
            if (tick) begin
               if (bit_idx_q == 3'd7) begin
                  state_d = ST_STOP;
                  tx_d    = 1'b1;
               end else begin
                  bit_idx_d = nxt_idx;
                  tx_d      = cur_byte[nxt_idx];
               end
            end
         end
         ST_STOP: begin
            if (tick) begin
               if (!byte_sel_q) begin
                  // High byte done: low byte follows with no idle gap.
                  byte_sel_d = 1'b1;
                  state_d    = ST_START;
                  tx_d       = 1'b0;
               end else begin
                  byte_sel_d = 1'b0;
                  state_d    = ST_IDLE;
                  busy_d     = 1'b0;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // A load drains the old buffered word on the same edge a new change
      // fills it, so that case is neither an overrun nor a lost pending.
      pend_word_d = change ? out_word : pend_word_q;
      pending_d   = change | (pending_q & ~load);
      overrun_d   = change & pending_q & ~load;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         bit_idx_q   <= 3'd0;
         byte_sel_q  <= 1'b0;
         word_q      <= 16'h0000;
         tx_q        <= 1'b1;
         busy_q      <= 1'b0;
         pending_q   <= 1'b0;
         pend_word_q <= 16'h0000;
         prev_q      <= 16'h0000;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_idx_q   <= bit_idx_d;
         byte_sel_q  <= byte_sel_d;
         word_q      <= word_d;
         tx_q        <= tx_d;
         busy_q      <= busy_d;
         pending_q   <= pending_d;
         pend_word_q <= pend_word_d;
         prev_q      <= out_word;
         overrun_q   <= overrun_d;
      end
   end

   assign tx      = tx_q;
   assign busy    = busy_q;
   assign pending = pending_q;
   assign overrun = overrun_q;

endmodule

// File: tb/tb_out_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_out_uart_tx
// Bench for out_uart_tx with CLKS_PER_BIT = 4. Expected bytes are queued when
// a word is driven; a line monitor decodes tx and pops/compares each byte.
// -----------------------------------------------------------------------------
module tb_out_uart_tx;

   localparam int C = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic [15:0] out_word;
   logic        tx, busy, pending, overrun;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int ovr_cnt = 0;

   logic [7:0] exp_q[$];
   int         start_cyc[$];

   typedef struct {
      logic [15:0] word;
      logic [7:0]  hi;
      logic [7:0]  lo;
   } vec_t;

   vec_t vecs[4];

   out_uart_tx #(.CLKS_PER_BIT(C)) dut (
      .clock    (clock),
      .reset    (reset),
      .out_word (out_word),
      .tx       (tx),
      .busy     (busy),
      .pending  (pending),
      .overrun  (overrun)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick_n(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic wait_busy(input int max, input string name);
      int n = 0;
      while (busy !== 1'b1 && n < max) begin
         @(negedge clock);
         n++;
      end
      if (busy !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL %s: busy still %b after %0d cycles, wanted 1", name, busy, n);
      end
   endtask

   task automatic wait_drain(input int max, input string name);
      int n = 0;
      while ((busy !== 1'b0 || pending !== 1'b0 || exp_q.size() != 0) && n < max) begin
         @(negedge clock);
         n++;
      end
      check(name, {busy, pending, exp_q.size() == 0}, 32'b001);
   endtask

   // Line monitor: samples mid-bit on falling edges; abandons a frame on reset.
   initial begin : monitor
      logic [7:0] rx;
      logic       ab;
      logic [7:0] e;
      forever begin
         @(negedge clock);
         if (reset !== 1'b0 || tx !== 1'b0) continue;
         start_cyc.push_back(cyc);
         ab = 1'b0;
         rx = 8'h00;
         for (int i = 0; i < C / 2 && !ab; i++) begin
            @(negedge clock);
            if (reset) ab = 1'b1;
         end
         if (ab) continue;
         check("start_bit", {31'b0, tx}, 32'd0);
         for (int b = 0; b < 9 && !ab; b++) begin
            for (int i = 0; i < C && !ab; i++) begin
               @(negedge clock);
               if (reset) ab = 1'b1;
            end
            if (!ab) begin
               if (b < 8) rx[b] = tx;
               else check("stop_bit", {31'b0, tx}, 32'd1);
            end
         end
         if (ab) continue;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: got %0h expected none", rx);
         end else begin
            e = exp_q.pop_front();
            check("rx_byte", {24'b0, rx}, {24'b0, e});
         end
      end
   end

   initial begin : ovr_count
      forever begin
         @(negedge clock);
         if (overrun === 1'b1) ovr_cnt++;
      end
   end

   initial begin : watchdog
      #(50000 * 10);
      $display("FAIL watchdog: run exceeded 50000 cycles");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int s0, o0, c0, bn;

      vecs[0] = '{word: 16'h7FFF, hi: 8'h7F, lo: 8'hFF};
      vecs[1] = '{word: 16'h8001, hi: 8'h80, lo: 8'h01};
      vecs[2] = '{word: 16'hA55A, hi: 8'hA5, lo: 8'h5A};
      vecs[3] = '{word: 16'h0100, hi: 8'h01, lo: 8'h00};

      // Reset held for 3 edges with a zero word.
      out_word = 16'h0000;
      reset    = 1'b1;
      tick_n(3);
      check("rst_tx",      {31'b0, tx},      32'd1);
      check("rst_busy",    {31'b0, busy},    32'd0);
      check("rst_pending", {31'b0, pending}, 32'd0);
      check("rst_overrun", {31'b0, overrun}, 32'd0);
      reset = 1'b0;
      s0 = start_cyc.size();
      tick_n(100);
      check("idle_no_frame", start_cyc.size() - s0, 0);
      check("idle_busy", {31'b0, busy}, 32'd0);

      // Single words from the table, each sent from idle.
      for (int i = 0; i < 4; i++) begin
         s0 = start_cyc.size();
         exp_q.push_back(vecs[i].hi);
         exp_q.push_back(vecs[i].lo);
         out_word = vecs[i].word;
         @(negedge clock);
         check("pend_after_change", {31'b0, pending}, 32'd1);
         check("busy_before_load",  {31'b0, busy},    32'd0);
         @(negedge clock);
         check("pend_after_load", {31'b0, pending}, 32'd0);
         check("busy_at_load",    {31'b0, busy},    32'd1);
         check("tx_start",        {31'b0, tx},      32'd0);
         bn = 0;
         while (busy === 1'b1 && bn < 200) begin
            bn++;
            @(negedge clock);
         end
         check("busy_cycles", bn, 80);
         tick_n(20);
         check("no_retx", start_cyc.size() - s0, 2);
         check("drained", exp_q.size(), 0);
         if (start_cyc.size() - s0 == 2)
            check("byte_gap", start_cyc[s0+1] - start_cyc[s0], 40);
      end

      // Buffering: second word arrives during the first frame.
      s0 = start_cyc.size();
      o0 = ovr_cnt;
      exp_q.push_back(8'h12); exp_q.push_back(8'h34);
      exp_q.push_back(8'h00); exp_q.push_back(8'hAB);
      out_word = 16'h1234;
      wait_busy(10, "buf_busy");
      tick_n(10);
      out_word = 16'h00AB;
      @(negedge clock);
      check("buf_pending", {31'b0, pending}, 32'd1);
      wait_drain(400, "buf_drain");
      check("buf_overrun", ovr_cnt - o0, 0);
      check("buf_frames", start_cyc.size() - s0, 4);
      if (start_cyc.size() - s0 >= 3)
         check("buf_spacing", start_cyc[s0+2] - start_cyc[s0], 81);

      // Overrun: AAAA is replaced by ABCD before it can be sent.
      o0 = ovr_cnt;
      exp_q.push_back(8'h12); exp_q.push_back(8'h34);
      exp_q.push_back(8'hAB); exp_q.push_back(8'hCD);
      out_word = 16'h1234;
      wait_busy(10, "ovr_busy");
      tick_n(5);
      out_word = 16'hAAAA;
      tick_n(3);
      check("ovr_none_yet", {31'b0, overrun}, 32'd0);
      out_word = 16'hABCD;
      @(negedge clock);
      check("ovr_pulse", {31'b0, overrun}, 32'd1);
      @(negedge clock);
      check("ovr_clear", {31'b0, overrun}, 32'd0);
      wait_drain(400, "ovr_drain");
      check("ovr_count", ovr_cnt - o0, 1);

      // Change on the same edge the buffered word is loaded.
      o0 = ovr_cnt;
      exp_q.push_back(8'h11); exp_q.push_back(8'h11);
      exp_q.push_back(8'h55); exp_q.push_back(8'h55);
      out_word = 16'h1111;
      @(negedge clock);
      out_word = 16'h5555;
      @(negedge clock);
      check("coin_pending", {31'b0, pending}, 32'd1);
      check("coin_busy",    {31'b0, busy},    32'd1);
      check("coin_overrun", {31'b0, overrun}, 32'd0);
      wait_drain(400, "coin_drain");
      check("coin_ovr_count", ovr_cnt - o0, 0);

      // Reset during DATA of the low byte, word held across reset.
      exp_q.push_back(8'h12); exp_q.push_back(8'h34);
      out_word = 16'h1234;
      wait_busy(10, "mid_busy");
      tick_n(50);
      reset = 1'b1;
      @(negedge clock);
      check("mid_rst_tx",      {31'b0, tx},      32'd1);
      check("mid_rst_busy",    {31'b0, busy},    32'd0);
      check("mid_rst_pending", {31'b0, pending}, 32'd0);
      @(negedge clock);
      exp_q.delete();
      exp_q.push_back(8'h12); exp_q.push_back(8'h34);
      s0 = start_cyc.size();
      c0 = cyc;
      reset = 1'b0;
      @(negedge clock);
      check("mid_re_pending", {31'b0, pending}, 32'd1);
      @(negedge clock);
      check("mid_re_busy", {31'b0, busy}, 32'd1);
      check("mid_re_tx",   {31'b0, tx},   32'd0);
      wait_drain(400, "mid_drain");
      check("mid_frames", start_cyc.size() - s0, 2);
      if (start_cyc.size() > s0)
         check("mid_start_time", start_cyc[s0] - c0, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
